// File: rtl/tt_um_round_ctrl.sv
// Round controller for a shooting game: arms a target, waits for a shot or timeout,
// judges hit/miss, and tracks score and remaining attempts.

module tt_um_round_ctrl #(
   parameter int SHOTS   = 16,
   parameter int TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       start,
   input  logic       shot_valid,
   input  logic [4:0] shot_x,
   input  logic [4:0] shot_y,
   input  logic [4:0] target_x,
   input  logic [4:0] target_y,
   output logic       new_target,
   output logic       hit,
   output logic       miss,
   output logic [7:0] score,
   output logic [7:0] shots_left,
   output logic       game_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      SETTLE = 3'd2,
      AIM    = 3'd3,
      JUDGE  = 3'd4,
      OVER   = 3'd5
   } roundState_t;

   localparam logic [7:0] SHOTS_INIT = 8'(SHOTS);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   roundState_t r_state;
   roundState_t w_nextState;

   logic [7:0] r_timer;
   logic       r_timeout;
   logic [4:0] r_shotX;
   logic [4:0] r_shotY;
   logic [7:0] r_score;
   logic [7:0] r_shotsLeft;

   logic w_match;
   logic w_expired;
   logic w_newTarget;
   logic w_hit;
   logic w_miss;

   assign w_match   = ({r_shotX, r_shotY} == {target_x, target_y});
   assign w_expired = (r_timer == TIMER_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A shot arriving on the last AIM cycle takes priority over the timeout.
   always_comb begin
      w_nextState = r_state;
      w_newTarget = 1'b0;
      w_hit       = 1'b0;
      w_miss      = 1'b0;
      case (r_state)
         IDLE, OVER: begin
            if (start) w_nextState = ARM;
         end
         ARM: begin
            w_newTarget = 1'b1;
            w_nextState = SETTLE;
         end
         SETTLE: begin
            w_nextState = AIM;
         end
         AIM: begin
            if (shot_valid || w_expired) w_nextState = JUDGE;
         end
         JUDGE: begin
            if (w_match && !r_timeout) w_hit = 1'b1;
            else w_miss = 1'b1;
            w_nextState = (r_shotsLeft == 8'd1) ? OVER : ARM;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (!ena) begin
         w_nextState = r_state;
         w_newTarget = 1'b0;
         w_hit       = 1'b0;
         w_miss      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer     <= 8'd0;
         r_timeout   <= 1'b0;
         r_shotX     <= 5'd0;
         r_shotY     <= 5'd0;
         r_score     <= 8'd0;
         r_shotsLeft <= 8'd0;
      end else if (ena) begin
         case (r_state)
            IDLE, OVER: begin
               if (start) begin
                  r_score     <= 8'd0;
                  r_shotsLeft <= SHOTS_INIT;
               end
            end
            SETTLE: begin
               r_timer <= 8'd0;
            end
            AIM: begin
               if (shot_valid) begin
                  r_shotX   <= shot_x;
                  r_shotY   <= shot_y;
                  r_timeout <= 1'b0;
               end else if (w_expired) begin
                  r_timeout <= 1'b1;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            JUDGE: begin
               r_shotsLeft <= r_shotsLeft - 8'd1;
               if (w_hit && (r_score != 8'd255)) r_score <= r_score + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign new_target = w_newTarget;
   assign hit        = w_hit;
   assign miss       = w_miss;
   assign score      = r_score;
   assign shots_left = r_shotsLeft;
   assign game_over  = (r_state == OVER);
   assign state      = r_state;

endmodule

// File: tb/tb_tt_um_round_ctrl.sv
// Directed-vector bench for tt_um_round_ctrl with SHOTS=2, TIMEOUT=4.

module tb_tt_um_round_ctrl;

   logic       clk;
   logic       reset;
   logic       ena;
   logic       start;
   logic       shotValid;
   logic [4:0] shotX;
   logic [4:0] shotY;
   logic [4:0] targetX;
   logic [4:0] targetY;
   logic       newTarget;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic [7:0] shotsLeft;
   logic       gameOver;
   logic [2:0] state;

   int vectorCount = 0;
   int missCount   = 0;

   tt_um_round_ctrl #(.SHOTS(2), .TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .ena        (ena),
      .start      (start),
      .shot_valid (shotValid),
      .shot_x     (shotX),
      .shot_y     (shotY),
      .target_x   (targetX),
      .target_y   (targetY),
      .new_target (newTarget),
      .hit        (hit),
      .miss       (miss),
      .score      (score),
      .shots_left (shotsLeft),
      .game_over  (gameOver),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends even if the stimulus stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic sv, input logic [4:0] sx, input logic [4:0] sy);
      start     = s;
      shotValid = sv;
      shotX     = sx;
      shotY     = sy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkPulses(input string tag, input logic nt, input logic h, input logic m);
      checkOutput({tag, ".newTarget"}, 8'(newTarget), 8'(nt));
      checkOutput({tag, ".hit"}, 8'(hit), 8'(h));
      checkOutput({tag, ".miss"}, 8'(miss), 8'(m));
   endtask

   initial begin
      targetX = 5'd19;
      targetY = 5'd6;
      reset   = 1'b0;
      ena     = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("rst.state", 8'(state), 8'd0);
      checkOutput("rst.score", score, 8'd0);
      checkOutput("rst.shotsLeft", shotsLeft, 8'd0);
      checkOutput("rst.gameOver", 8'(gameOver), 8'd0);
      checkPulses("rst", 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkOutput("idle.state", 8'(state), 8'd0);

      // Scenario 1: two direct hits end the game.
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s1.armState", 8'(state), 8'd1);
      checkOutput("s1.shotsLeft", shotsLeft, 8'd2);
      checkPulses("s1.arm", 1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            checkOutput("s1.rearm", 8'(state), 8'd1);
            checkOutput("s1.score1", score, 8'd1);
            checkOutput("s1.left1", shotsLeft, 8'd1);
         end
         tick();
         checkOutput("s1.settle", 8'(state), 8'd2);
         checkPulses("s1.settle", 1'b0, 1'b0, 1'b0);
         tick();
         checkOutput("s1.aim", 8'(state), 8'd3);
         applyStimulus(1'b0, 1'b1, 5'd19, 5'd6);
         tick();
         applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
         checkOutput("s1.judge", 8'(state), 8'd4);
         checkPulses("s1.judge", 1'b0, 1'b1, 1'b0);
         tick();
      end
      checkOutput("s1.overState", 8'(state), 8'd5);
      checkOutput("s1.score", score, 8'd2);
      checkOutput("s1.shotsLeft0", shotsLeft, 8'd0);
      checkOutput("s1.gameOver", 8'(gameOver), 8'd1);
      tick();
      checkOutput("s1.overHold", 8'(state), 8'd5);

      // Scenario 2: no shot, AIM times out after exactly 4 cycles.
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s2.arm", 8'(state), 8'd1);
      checkOutput("s2.scoreCleared", score, 8'd0);
      checkOutput("s2.gameOverLow", 8'(gameOver), 8'd0);
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         checkOutput($sformatf("s2.aim%0d", c), 8'(state), 8'd3);
         checkPulses("s2.aim", 1'b0, 1'b0, 1'b0);
         tick();
      end
      checkOutput("s2.judge", 8'(state), 8'd4);
      checkPulses("s2.judge", 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("s2.score", score, 8'd0);
      checkOutput("s2.shotsLeft", shotsLeft, 8'd1);
      checkOutput("s2.rearm", 8'(state), 8'd1);

      // Scenario 4: shot in SETTLE ignored; y bit 4 flipped is a miss.
      tick();
      applyStimulus(1'b0, 1'b1, 5'd19, 5'd6);
      checkOutput("s4.settle", 8'(state), 8'd2);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s4.aim", 8'(state), 8'd3);
      tick();
      checkOutput("s4.aimWaits", 8'(state), 8'd3);
      applyStimulus(1'b0, 1'b1, 5'd19, 5'd22);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s4.judge", 8'(state), 8'd4);
      checkPulses("s4.judge", 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("s4.over", 8'(state), 8'd5);
      checkOutput("s4.score", score, 8'd0);

      // Scenario 3: shot on the final AIM cycle beats the timeout.
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      tick();
      tick();
      tick();
      tick();
      checkOutput("s3.lastAim", 8'(state), 8'd3);
      applyStimulus(1'b0, 1'b1, 5'd19, 5'd6);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s3.judge", 8'(state), 8'd4);
      checkPulses("s3.judge", 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("s3.score", score, 8'd1);
      checkOutput("s3.shotsLeft", shotsLeft, 8'd1);

      // Scenario 5: ena low for 10 cycles in AIM freezes everything.
      tick();
      tick();
      tick();
      checkOutput("s5.aimT1", 8'(state), 8'd3);
      ena = 1'b0;
      applyStimulus(1'b1, 1'b1, 5'd19, 5'd6);
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("s5.frozenState", 8'(state), 8'd3);
         checkPulses("s5.frozen", 1'b0, 1'b0, 1'b0);
      end
      checkOutput("s5.frozenScore", score, 8'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      ena = 1'b1;
      tick();
      tick();
      checkOutput("s5.resumeAim", 8'(state), 8'd3);
      tick();
      checkOutput("s5.judge", 8'(state), 8'd4);
      checkPulses("s5.judge", 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("s5.over", 8'(state), 8'd5);
      checkOutput("s5.score", score, 8'd1);
      checkOutput("s5.shotsLeft", shotsLeft, 8'd0);

      // Scenario 6: asynchronous reset in JUDGE aborts with no verdict.
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 5'd19, 5'd6);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkPulses("s6.preReset", 1'b0, 1'b1, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("s6.state", 8'(state), 8'd0);
      checkPulses("s6.reset", 1'b0, 1'b0, 1'b0);
      checkOutput("s6.score", score, 8'd0);
      checkOutput("s6.shotsLeft", shotsLeft, 8'd0);
      reset = 1'b1;
      tick();
      checkOutput("s6.idleWait", 8'(state), 8'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
      checkOutput("s6.restartState", 8'(state), 8'd1);
      checkOutput("s6.restartLeft", shotsLeft, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
